// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID pipeline latch.
// It owns the PC and the instruction-memory read handshake. Stall, redirect
// and halt requests come from later stages. A redirect that arrives while an
// instruction-memory miss is outstanding is parked in pend_pc_r until the
// miss completes, because the memory side cannot abort a read.
module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter logic [31:0] PC_STEP = 32'd4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        stall_i,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   input  logic        halt_i,
   output logic        iREN,
   output logic [31:0] imemaddr,
   output logic [31:0] npc_o,
   output logic [31:0] iload_o,
   output logic        iien_o,
   output logic        flush_o,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_DRAIN = 2'b01,
      ST_HALT  = 2'b10
   } state_t;

   state_t      state_r;
   logic [31:0] pc_r;
   logic [31:0] pend_pc_r;
   logic [31:0] fetch_count_r;

   logic [31:0] target_s;
   logic        iren_s;
   logic        iien_s;
   logic        flush_s;

   // Redirect targets are forced to word alignment; the low two bits are dropped.
   assign target_s = redirect_pc & 32'hFFFF_FFFC;

   assign imemaddr    = pc_r;
   assign npc_o       = pc_r + PC_STEP;
   assign iload_o     = imemload;
   assign iREN        = iren_s;
   assign iien_o      = iien_s;
   assign flush_o     = flush_s;
   assign fetch_count = fetch_count_r;

   // Latch-control and read-enable decode from the current state and requests.
   always_comb begin
      iren_s  = 1'b0;
      iien_s  = 1'b0;
      flush_s = 1'b0;
      if (RST) begin
         iren_s  = 1'b0;
         iien_s  = 1'b0;
         flush_s = 1'b1;
      end else begin
         case (state_r)
            ST_FETCH: begin
               iren_s = 1'b1;
               if (redirect_en) begin
                  flush_s = 1'b1;
               end else if (halt_i) begin
                  flush_s = 1'b1;
               end else if (ihit && !stall_i) begin
                  iien_s = 1'b1;
               end else begin
                  iien_s  = 1'b0;
                  flush_s = 1'b0;
               end
            end
            ST_DRAIN: begin
               // The word in flight belongs to the wrong path; keep the latch flushed.
               iren_s  = 1'b1;
               flush_s = 1'b1;
            end
            ST_HALT: begin
               iren_s  = 1'b0;
               flush_s = 1'b0;
            end
            default: begin
               iren_s  = 1'b0;
               flush_s = 1'b1;
            end
         endcase
      end
   end

   // PC, parked redirect target, fetch FSM and delivered-instruction counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_r          <= PC_INIT;
         pend_pc_r     <= 32'h0000_0000;
         state_r       <= ST_FETCH;
         fetch_count_r <= 32'h0000_0000;
      end else begin
         case (state_r)
            ST_FETCH: begin
               if (redirect_en) begin
                  if (ihit) begin
                     pc_r <= target_s;
                  end else begin
                     pend_pc_r <= target_s;
                     state_r   <= ST_DRAIN;
                  end
               end else if (halt_i) begin
                  state_r <= ST_HALT;
               end else if (ihit && !stall_i) begin
                  pc_r          <= pc_r + PC_STEP;
                  fetch_count_r <= fetch_count_r + 32'd1;
               end else begin
                  pc_r <= pc_r;
               end
            end
            ST_DRAIN: begin
               // Last redirect wins; a redirect coinciding with the hit is used directly.
               if (ihit) begin
                  pc_r    <= redirect_en ? target_s : pend_pc_r;
                  state_r <= ST_FETCH;
               end else if (redirect_en) begin
                  pend_pc_r <= target_s;
               end else begin
                  pend_pc_r <= pend_pc_r;
               end
            end
            ST_HALT: begin
               state_r <= ST_HALT;
            end
            default: begin
               state_r <= ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus process pushes hand-computed
// expected outputs per cycle; a monitor pops and compares them mid-cycle.
module tb_fetch_unit;

   typedef struct packed {
      logic        iren;
      logic [31:0] addr;
      logic [31:0] npc;
      logic [31:0] iload;
      logic        iien;
      logic        flush;
      logic [31:0] cnt;
   } resp_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit;
   logic [31:0] imemload;
   logic        stall_i;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        halt_i;
   logic        iREN;
   logic [31:0] imemaddr;
   logic [31:0] npc_o;
   logic [31:0] iload_o;
   logic        iien_o;
   logic        flush_o;
   logic [31:0] fetch_count;

   logic        w_iren;
   logic [31:0] w_addr;
   logic [31:0] w_npc;
   logic [31:0] w_iload;
   logic        w_iien;
   logic        w_flush;
   logic [31:0] w_cnt;

   resp_t sb[$];
   resp_t wq[$];
   int    vectors = 0;
   int    miscompares = 0;

   always #5 CLK = ~CLK;

   fetch_unit #(.PC_INIT(32'h0000_0000), .PC_STEP(32'd4)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
      .stall_i(stall_i), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .halt_i(halt_i), .iREN(iREN), .imemaddr(imemaddr), .npc_o(npc_o),
      .iload_o(iload_o), .iien_o(iien_o), .flush_o(flush_o),
      .fetch_count(fetch_count)
   );

   fetch_unit #(.PC_INIT(32'hFFFF_FFFC), .PC_STEP(32'd4)) u_wrap (
      .CLK(CLK), .RST(RST), .ihit(1'b1), .imemload(32'h1234_5678),
      .stall_i(1'b0), .redirect_en(1'b0), .redirect_pc(32'h0000_0000),
      .halt_i(1'b0), .iREN(w_iren), .imemaddr(w_addr), .npc_o(w_npc),
      .iload_o(w_iload), .iien_o(w_iien), .flush_o(w_flush),
      .fetch_count(w_cnt)
   );

   task automatic cmp(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s.%s got %h expected %h", tag, fld, act, exp);
      end
   endtask

   task automatic chk(input string tag, input resp_t a, input resp_t e);
      cmp(tag, "iREN",        {31'd0, a.iren},  {31'd0, e.iren});
      cmp(tag, "imemaddr",    a.addr,           e.addr);
      cmp(tag, "npc_o",       a.npc,            e.npc);
      cmp(tag, "iload_o",     a.iload,          e.iload);
      cmp(tag, "iien_o",      {31'd0, a.iien},  {31'd0, e.iien});
      cmp(tag, "flush_o",     {31'd0, a.flush}, {31'd0, e.flush});
      cmp(tag, "fetch_count", a.cnt,            e.cnt);
   endtask

   // Drive one cycle of inputs at the falling edge and queue the expected outputs.
   task automatic step(input logic rst, input logic ih, input logic st, input logic re,
                       input logic [31:0] rpc, input logic hl,
                       input logic e_iren, input logic [31:0] e_addr,
                       input logic e_iien, input logic e_flush, input logic [31:0] e_cnt);
      resp_t e;
      @(negedge CLK);
      RST         = rst;
      ihit        = ih;
      stall_i     = st;
      redirect_en = re;
      redirect_pc = rpc;
      halt_i      = hl;
      imemload    = 32'hC0DE_0000 ^ e_addr;
      e.iren  = e_iren;
      e.addr  = e_addr;
      e.npc   = e_addr + 32'd4;
      e.iload = 32'hC0DE_0000 ^ e_addr;
      e.iien  = e_iien;
      e.flush = e_flush;
      e.cnt   = e_cnt;
      sb.push_back(e);
   endtask

   // Monitor: sample mid-low-phase and pop the expected response for this cycle.
   initial begin
      resp_t a;
      resp_t e;
      forever begin
         @(negedge CLK);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            a = '{iREN, imemaddr, npc_o, iload_o, iien_o, flush_o, fetch_count};
            chk("main", a, e);
         end
         if (wq.size() > 0) begin
            e = wq.pop_front();
            a = '{w_iren, w_addr, w_npc, w_iload, w_iien, w_flush, w_cnt};
            chk("wrap", a, e);
         end
      end
   end

   initial begin
      RST = 1'b1; ihit = 1'b0; imemload = 32'h0; stall_i = 1'b0;
      redirect_en = 1'b0; redirect_pc = 32'h0; halt_i = 1'b0;
      repeat (2) @(posedge CLK);

      wq.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b1, 32'd0});
      wq.push_back('{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0, 32'd0});
      wq.push_back('{1'b1, 32'h0000_0000, 32'h0000_0004, 32'h1234_5678, 1'b1, 1'b0, 32'd1});

      //    rst  ih   st   re   rpc           hl     iren addr          iien flush cnt
      step(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,  1'b0,32'h0,        1'b0,1'b1,32'd0); // reset
      step(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,  1'b1,32'h0,        1'b1,1'b0,32'd0); // sequential
      step(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,  1'b1,32'h4,        1'b1,1'b0,32'd1);
      step(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,  1'b1,32'h8,        1'b1,1'b0,32'd2);
      step(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,  1'b1,32'hC,        1'b1,1'b0,32'd3);
      step(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,  1'b1,32'h10,       1'b0,1'b0,32'd4); // stall x3
      step(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,  1'b1,32'h10,       1'b0,1'b0,32'd4);
      step(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,  1'b1,32'h10,       1'b0,1'b0,32'd4);
      step(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,  1'b1,32'h10,       1'b1,1'b0,32'd4); // release
      step(1'b0,1'b1,1'b1,1'b1,32'h200,      1'b0,  1'b1,32'h14,       1'b0,1'b1,32'd5); // redirect on hit, stalled
      step(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,  1'b1,32'h200,      1'b1,1'b0,32'd5);
      step(1'b0,1'b0,1'b0,1'b1,32'h300,      1'b0,  1'b1,32'h204,      1'b0,1'b1,32'd6); // redirect on miss
      step(1'b0,1'b0,1'b0,1'b1,32'h400,      1'b0,  1'b1,32'h204,      1'b0,1'b1,32'd6); // last wins
      step(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,  1'b1,32'h204,      1'b0,1'b1,32'd6); // halt ignored
      step(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,  1'b1,32'h204,      1'b0,1'b1,32'd6); // miss completes
      step(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,  1'b1,32'h400,      1'b1,1'b0,32'd6);
      step(1'b0,1'b1,1'b0,1'b1,32'h103,      1'b0,  1'b1,32'h404,      1'b0,1'b1,32'd7); // misaligned target
      step(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,  1'b1,32'h100,      1'b1,1'b0,32'd7);
      step(1'b0,1'b0,1'b0,1'b1,32'h300,      1'b0,  1'b1,32'h104,      1'b0,1'b1,32'd8); // drain ...
      step(1'b0,1'b1,1'b0,1'b1,32'h502,      1'b0,  1'b1,32'h104,      1'b0,1'b1,32'd8); // ... hit with new redirect
      step(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,  1'b1,32'h500,      1'b1,1'b0,32'd8);
      step(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,  1'b1,32'h504,      1'b0,1'b0,32'd9); // plain miss
      step(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1,  1'b1,32'h504,      1'b0,1'b1,32'd9); // halt
      step(1'b0,1'b1,1'b0,1'b1,32'h500,      1'b0,  1'b0,32'h504,      1'b0,1'b0,32'd9); // redirect ignored
      step(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,  1'b0,32'h504,      1'b0,1'b0,32'd9);
      step(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,  1'b0,32'h504,      1'b0,1'b1,32'd9); // reset out of halt
      step(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,  1'b1,32'h0,        1'b1,1'b0,32'd0);
      step(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,  1'b1,32'h4,        1'b1,1'b0,32'd1);
      step(1'b0,1'b0,1'b0,1'b1,32'h700,      1'b0,  1'b1,32'h8,        1'b0,1'b1,32'd2); // enter drain
      step(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,  1'b0,32'h8,        1'b0,1'b1,32'd2); // reset mid-drain
      step(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,  1'b1,32'h0,        1'b1,1'b0,32'd0);

      for (int i = 0; i < 10; i++) begin
         if (sb.size() != 0 || wq.size() != 0) @(negedge CLK);
      end
      #3;
      if (sb.size() != 0 || wq.size() != 0) begin
         miscompares++;
         $display("FAIL drain scoreboard left %0d/%0d expected 0/0", sb.size(), wq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that produces the inputs to the IF/ID pipeline latch: npc, iload, the latch enable and the latch flush. It owns the PC, drives the instruction-memory read handshake, and accepts stall, redirect (branch/jump) and halt requests from later stages. A redirect that arrives during an outstanding instruction-memory miss is parked until the miss completes, because the memory side cannot abort a read.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment per sequential fetch.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST  in  1  synchronous reset, active-high.
ihit  in  1  instruction memory returns valid imemload this cycle.
imemload  in  32  instruction word at imemaddr.
stall_i  in  1  hazard unit requests IF/ID hold.
redirect_en  in  1  branch/jump taken; fetch must restart at redirect_pc.
redirect_pc  in  32  redirect target.
halt_i  in  1  halt decoded; stop fetching.
iREN  out  1  instruction read enable.
imemaddr  out  32  fetch address (current PC).
npc_o  out  32  PC+PC_STEP of the fetched word, to the IF/ID latch npc input.
iload_o  out  32  fetched word, to the IF/ID latch iload input.
iien_o  out  1  IF/ID latch enable.
flush_o  out  1  IF/ID latch flush.
fetch_count  out  32  number of instructions handed to IF/ID since reset.

Behaviour:
- Registers: pc, pend_pc, state {FETCH, DRAIN, HALT}, fetch_count. All other outputs are combinational from the registers and the current inputs.
- RST high at a rising edge: pc=PC_INIT, pend_pc=0, state=FETCH, fetch_count=0.
- While RST is high, outputs are forced: iREN=0, iien_o=0, flush_o=1. flush_o=1 clears the IF/ID latch in the same cycle.
- In every state: imemaddr=pc, npc_o=pc+PC_STEP (mod 2^32; 32'hFFFF_FFFC wraps to 0), iload_o=imemload.
- Target alignment: redirect_pc[1:0] is ignored and treated as 2'b00.
- FETCH, iREN=1. Priority order:
  1) redirect_en, ihit=1: pc<=redirect_pc; flush_o=1, iien_o=0; stay in FETCH.
  2) redirect_en, ihit=0: pend_pc<=redirect_pc; flush_o=1, iien_o=0; go to DRAIN.
  3) halt_i: flush_o=1, iien_o=0; go to HALT; pc is held.
  4) ihit=1, stall_i=0: iien_o=1, flush_o=0; pc<=pc+PC_STEP; fetch_count++.
  5) ihit=1, stall_i=1: iien_o=0, flush_o=0; pc is held, so the same word is refetched next cycle.
  6) ihit=0: iien_o=0, flush_o=0; pc is held.
- Redirect beats stall: a stall never blocks a redirect.
- DRAIN, iREN=1, imemaddr stays at the old pc:
  - flush_o=1 and iien_o=0 every cycle.
  - A new redirect_en overwrites pend_pc (last redirect wins).
  - halt_i is ignored, since it comes from the wrong path.
  - On ihit=1: the returned word is discarded; pc<=the redirect target (the one arriving this cycle if redirect_en, else pend_pc); go to FETCH.
- HALT: iREN=0, iien_o=0, flush_o=0; pc frozen. Sticky until RST. redirect_en and stall_i are ignored.
- Latency: a redirect with ihit=1 issues a fetch at the target in the next cycle. A redirect during a miss issues it in the cycle after the miss completes.
- fetch_count wraps modulo 2^32 and increments only on iien_o=1.
- Reset mid-DRAIN or mid-HALT: the pending target is lost and fetch restarts at PC_INIT.

Test Plan:
- Sequential fetch. PC_INIT=0, ihit=1 always, imemload=address-derived. → imemaddr 0,4,8,C on consecutive cycles; iien_o=1 each cycle; npc_o=4,8,C,10; fetch_count=4 after 4 cycles.
- Stall. At pc=8, stall_i=1 for 3 cycles. → imemaddr stays 8; iien_o=0 for 3 cycles; on release, npc_o=C with iien_o=1; fetch_count unchanged during the stall.
- Redirect on hit. At pc=10, redirect_en=1, redirect_pc=200, ihit=1, stall_i=1. → flush_o=1 and iien_o=0 that cycle; next imemaddr=200 (redirect overrides stall).
- Redirect during miss. At pc=20, ihit=0; redirect_en=1 to 300, then redirect_en=1 to 400 one cycle later; ihit=1 after 4 cycles. → imemaddr stays 20 through DRAIN; flush_o=1 every DRAIN cycle; no iien_o; next imemaddr=400.
- Halt. halt_i=1 at pc=40. → HALT next cycle: iREN=0, imemaddr=40 frozen. A later redirect_en to 500 has no effect. RST=1 for one edge → imemaddr=0, iREN=1.
- Wrap and alignment. PC_INIT=32'hFFFF_FFFC, ihit=1. → npc_o=0, next imemaddr=0. Separately, redirect_pc=32'h0000_0103 → imemaddr=32'h0000_0100.
